div_three_sched: RTL and testbench

// - Shares one div_three serial divisibility checker among NREQ requesters.
// - Round-robin arbitration picks one requester, which hands over a W-bit word.
// - The word is serialized LSB-first with start/finish strobes, the verdict is collected,
//   and the result is returned tagged with the requester id.
// - Sits between parallel producers and the single div_three instance.

---
 rtl/div_three_sched_pkg.sv | 19 +
 rtl/div_three_sched_if.sv | 32 +++
 rtl/div_three_sched_rr_arbiter.sv | 28 ++
 rtl/div_three_sched.sv | 108 ++++++++++
 tb/tb_div_three_sched.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/div_three_sched_pkg.sv
// Shared types for the div_three scheduler: FSM encoding and a width helper.
package div_three_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // ceil(log2(n)), but never below 1 so single-entry fields still get a bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/div_three_sched_if.sv
// Bundle of requester, div_three and response signals around the scheduler.
interface div_three_sched_if
  import div_three_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 8
);
  localparam int IDW = clog2_min1(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              div_data;
  logic              div_start;
  logic              div_finish;
  logic              div_result;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_div3;
  logic              busy;

  // master: requesters plus the div_three instance; slave: the scheduler
  modport master (
    output req_valid, req_data, div_result,
    input  req_ready, div_data, div_start, div_finish, rsp_valid, rsp_id, rsp_div3, busy
  );

  modport slave (
    input  req_valid, req_data, div_result,
    output req_ready, div_data, div_start, div_finish, rsp_valid, rsp_id, rsp_div3, busy
  );
endinterface

// File: rtl/div_three_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after last_grant+1 (mod NREQ).
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);
  logic found;
  int   pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int off = 1; off <= NREQ; off++) begin
      pos = (int'(last_grant) + off) % NREQ;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = IDW'(pos);
      end
    end
  end
endmodule

// File: rtl/div_three_sched.sv
// Shares one serial div_three checker among NREQ requesters: RR grant, LSB-first
// serialisation with start/finish strobes, verdict returned tagged with requester id.
module div_three_sched
  import div_three_sched_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int W       = 8,
  parameter int RES_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  div_three_sched_if.slave  bus
);
  localparam int IDW = clog2_min1(NREQ);
  localparam int CW  = clog2_min1(W);
  localparam int WCW = clog2_min1(RES_LAT + 1);

  state_t          state;
  logic [W-1:0]    shreg;
  logic [CW-1:0]   bit_cnt;
  logic [WCW-1:0]  wait_cnt;
  logic [IDW-1:0]  cur_id;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  g_idx;
  logic [NREQ-1:0] grant;
  logic [W-1:0]    sel_word;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic            rsp_div3_q;
  logic            in_shift;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .idx        (g_idx)
  );

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) sel_word = bus.req_data[i*W +: W];
    end
  end

  assign in_shift       = (state == ST_SHIFT);
  // Accept is only offered from IDLE, and never while reset is asserted.
  assign bus.req_ready  = (state == ST_IDLE && !rst) ? grant : '0;
  assign bus.div_data   = in_shift & shreg[0];
  assign bus.div_start  = in_shift && (bit_cnt == '0);
  assign bus.div_finish = in_shift && (bit_cnt == CW'(W - 1));
  assign bus.busy       = (state != ST_IDLE);
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_div3   = rsp_div3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      wait_cnt    <= '0;
      cur_id      <= '0;
      last_grant  <= IDW'(NREQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_div3_q  <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (|bus.req_valid) begin
            shreg   <= sel_word;
            cur_id  <= g_idx;
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shreg <= shreg >> 1;
          if (bit_cnt == CW'(W - 1)) begin
            wait_cnt <= '0;
            state    <= ST_WAIT;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          // Verdict is valid in the last wait cycle; register it with the pulse.
          if (wait_cnt == WCW'(RES_LAT - 1)) begin
            rsp_div3_q  <= bus.div_result;
            rsp_id_q    <= cur_id;
            rsp_valid_q <= 1'b1;
            last_grant  <= cur_id;
            state       <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_three_sched.sv
// Directed bench for div_three_sched (W=8 and W=1 instances) with a behavioural div_three.
module tb_div_three_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_three_sched_if #(.NREQ(2), .W(8)) b0 ();
  div_three_sched_if #(.NREQ(2), .W(1)) b1 ();

  div_three_sched #(.NREQ(2), .W(8), .RES_LAT(1)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  div_three_sched #(.NREQ(2), .W(1), .RES_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  // Serial mod-3 checker: LSB-first bit weights alternate 1,2,1,2 mod 3.
  logic [1:0] rem0, rem1;
  logic       wt0, wt1;
  always_ff @(posedge clk) begin
    if (rst) begin
      rem0 <= '0; wt0 <= 1'b0;
    end else if (b0.div_start) begin
      rem0 <= {1'b0, b0.div_data}; wt0 <= 1'b1;
    end else begin
      rem0 <= 2'((int'(rem0) + (b0.div_data ? (wt0 ? 2 : 1) : 0)) % 3); wt0 <= ~wt0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rem1 <= '0; wt1 <= 1'b0;
    end else if (b1.div_start) begin
      rem1 <= {1'b0, b1.div_data}; wt1 <= 1'b1;
    end else begin
      rem1 <= 2'((int'(rem1) + (b1.div_data ? (wt1 ? 2 : 1) : 0)) % 3); wt1 <= ~wt1;
    end
  end
  assign b0.div_result = (rem0 == 2'd0);
  assign b1.div_result = (rem1 == 2'd0);

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       exp_div3;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [15:0] d;
    d = 16'h5A5A;
    d[v.id*8 +: 8] = v.data;
    b0.req_valid = 2'(1 << v.id);
    b0.req_data  = d;
    @(negedge clk);
    chk("accept_ready", int'(b0.req_ready), 1 << v.id);
    chk("accept_busy", int'(b0.busy), 0);
    adv();
    b0.req_valid = '0;
    b0.req_data  = ~d;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("shift_bit", int'(b0.div_data), int'(v.data[k]));
      chk("shift_start", int'(b0.div_start), int'(k == 0));
      chk("shift_finish", int'(b0.div_finish), int'(k == 7));
      chk("shift_no_rsp", int'(b0.rsp_valid), 0);
      adv();
    end
    @(negedge clk);
    chk("wait_no_rsp", int'(b0.rsp_valid), 0);
    chk("wait_data_quiet", int'(b0.div_data | b0.div_start | b0.div_finish), 0);
    adv();
    @(negedge clk);
    chk("done_rsp_valid", int'(b0.rsp_valid), 1);
    chk("done_rsp_id", int'(b0.rsp_id), v.id);
    chk("done_rsp_div3", int'(b0.rsp_div3), int'(v.exp_div3));
    adv();
    @(negedge clk);
    chk("post_rsp_valid", int'(b0.rsp_valid), 0);
    chk("post_busy", int'(b0.busy), 0);
    chk("post_id_hold", int'(b0.rsp_id), v.id);
    adv();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vec_t v1[2];
    int gid[5];
    int gcyc[5];
    int ng, nrdy, nrsp, last_id;
    int exp_g[5];

    vecs[0] = '{id: 0, data: 8'd129, exp_div3: 1'b1};
    vecs[1] = '{id: 1, data: 8'd128, exp_div3: 1'b0};
    vecs[2] = '{id: 0, data: 8'd136, exp_div3: 1'b0};
    vecs[3] = '{id: 1, data: 8'd255, exp_div3: 1'b1};
    vecs[4] = '{id: 0, data: 8'd0,   exp_div3: 1'b1};
    vecs[5] = '{id: 1, data: 8'd7,   exp_div3: 1'b0};
    v1[0]   = '{id: 0, data: 8'd0,   exp_div3: 1'b1};
    v1[1]   = '{id: 1, data: 8'd1,   exp_div3: 1'b0};
    exp_g   = '{0, 1, 0, 1, 0};

    b0.req_valid = '0; b0.req_data = '0;
    b1.req_valid = '0; b1.req_data = '0;
    rst = 1'b1;
    adv(); adv();
    @(negedge clk);
    chk("reset_busy", int'(b0.busy), 0);
    chk("reset_rsp_valid", int'(b0.rsp_valid), 0);
    chk("reset_rsp_id", int'(b0.rsp_id), 0);
    chk("reset_rsp_div3", int'(b0.rsp_div3), 0);
    chk("reset_div_lines", int'(b0.div_data | b0.div_start | b0.div_finish), 0);
    chk("reset_ready", int'(b0.req_ready), 0);
    adv();
    rst = 1'b0;
    adv();

    // Single transactions, each from an idle scheduler.
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Both requesters held: alternating grants at the minimum period.
    for (int i = 0; i < 5; i++) begin gid[i] = -1; gcyc[i] = -1; end
    ng = 0;
    b0.req_valid = 2'b11;
    b0.req_data  = 16'h0000;
    for (int c = 0; c < 80 && ng < 5; c++) begin
      @(negedge clk);
      if (b0.req_ready != 2'b00) begin
        gid[ng]  = (b0.req_ready == 2'b01) ? 0 : ((b0.req_ready == 2'b10) ? 1 : 99);
        gcyc[ng] = c;
        ng++;
      end
      adv();
    end
    b0.req_valid = '0;
    chk("rr_grant_count", ng, 5);
    for (int i = 0; i < 5; i++) chk("rr_grant_order", gid[i], exp_g[i]);
    for (int i = 1; i < 5; i++) chk("rr_grant_spacing", gcyc[i] - gcyc[i-1], 11);
    for (int c = 0; c < 30 && b0.busy; c++) adv();
    @(negedge clk);
    chk("rr_drain_idle", int'(b0.busy), 0);
    adv();

    // Reset in the middle of SHIFT: pointer reverts so requester 0 wins next.
    b0.req_valid = 2'b11;
    b0.req_data  = 16'h0703;
    @(negedge clk);
    chk("abort_first_grant", int'(b0.req_ready), 2);
    adv();
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      chk("abort_no_finish", int'(b0.div_finish), 0);
      adv();
    end
    rst = 1'b1;
    adv();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(b0.busy), 0);
    chk("abort_div_lines", int'(b0.div_data | b0.div_start | b0.div_finish), 0);
    chk("abort_no_rsp", int'(b0.rsp_valid), 0);
    chk("abort_regrant", int'(b0.req_ready), 1);
    adv();
    b0.req_valid = '0;
    nrsp = 0; last_id = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (b0.rsp_valid) begin nrsp++; last_id = int'(b0.rsp_id); end
      adv();
    end
    chk("abort_rsp_count", nrsp, 1);
    chk("abort_rsp_id", last_id, 0);
    chk("abort_rsp_div3", int'(b0.rsp_div3), 1);

    // Requester 0 pulses once while requester 1 is being served.
    b0.req_valid = 2'b10;
    b0.req_data  = 16'h0500;
    @(negedge clk);
    chk("drop_grant1", int'(b0.req_ready), 2);
    nrdy = 0; nrsp = 0; last_id = -1;
    for (int c = 1; c <= 20; c++) begin
      adv();
      b0.req_valid = (c == 1) ? 2'b01 : 2'b00;
      @(negedge clk);
      if (b0.req_ready != 2'b00) nrdy++;
      if (b0.rsp_valid) begin nrsp++; last_id = int'(b0.rsp_id); end
    end
    adv();
    chk("drop_no_extra_grant", nrdy, 0);
    chk("drop_rsp_count", nrsp, 1);
    chk("drop_rsp_id", last_id, 1);
    chk("drop_rsp_div3", int'(b0.rsp_div3), 0);

    // W=1: start and finish coincide.
    for (int i = 0; i < 2; i++) begin
      b1.req_valid = 2'(1 << v1[i].id);
      b1.req_data  = 2'(int'(v1[i].data[0]) << v1[i].id);
      @(negedge clk);
      chk("w1_ready", int'(b1.req_ready), 1 << v1[i].id);
      adv();
      b1.req_valid = '0;
      @(negedge clk);
      chk("w1_start", int'(b1.div_start), 1);
      chk("w1_finish", int'(b1.div_finish), 1);
      chk("w1_bit", int'(b1.div_data), int'(v1[i].data[0]));
      adv();
      @(negedge clk);
      chk("w1_wait_no_rsp", int'(b1.rsp_valid), 0);
      adv();
      @(negedge clk);
      chk("w1_rsp_valid", int'(b1.rsp_valid), 1);
      chk("w1_rsp_id", int'(b1.rsp_id), v1[i].id);
      chk("w1_rsp_div3", int'(b1.rsp_div3), int'(v1[i].exp_div3));
      adv();
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
